aes_key_expand: RTL and testbench



---
 rtl/aes_key_expand.sv | 170 +++++++++++++++++
 tb/tb_aes_key_expand.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// Iterative AES-128/AES-256 key expansion: one 128-bit round key per clock into a flop buffer.
// Optional key wipe on i_zeroize is compiled in with AES_KEY_ZEROIZE_EN.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = x;
        bb = z;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // Multiplicative inverse as a^254 (maps 0 to 0), followed by the affine transform.
    always_comb begin
        sq  = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
            {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_expand #(
    parameter int KEY_W = 128
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_key_vld,
    input  logic [KEY_W-1:0] i_key,
    output logic             o_key_rdy,
    output logic             o_done,
    input  logic [3:0]       i_rk_rd_idx,
    output logic [127:0]     o_rk,
    input  logic             i_zeroize
);
    if (KEY_W != 128 && KEY_W != 256) begin : g_bad_key_w
        $error("aes_key_expand: KEY_W must be 128 or 256");
    end

    localparam int          NR    = (KEY_W == 256) ? 14 : 10;
    localparam logic [3:0]  LAST  = 4'(NR);
    localparam logic [3:0]  FIRST = (KEY_W == 256) ? 4'd2 : 4'd1;

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state;
    logic [3:0]   rnd;
    logic [127:0] rk_buf [0:NR];
    logic         wipe;
    logic         accept;

`ifdef AES_KEY_ZEROIZE_EN
    assign wipe = i_zeroize;
`else
    logic unused_zeroize;
    assign unused_zeroize = i_zeroize;
    assign wipe = 1'b0;
`endif

    assign accept = i_key_vld && o_key_rdy;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [127:0] prev;
    logic [127:0] base;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [31:0]  temp;
    logic [3:0]   rcon_idx;
    logic         use_rot;
    logic [127:0] next_rk;

    // AES-256 odd rounds take SubWord only; even rounds and all AES-128 rounds rotate and add Rcon.
    always_comb begin
        prev     = rk_buf[rnd - 4'd1];
        base     = (KEY_W == 256) ? rk_buf[rnd - 4'd2] : prev;
        use_rot  = (KEY_W == 128) || !rnd[0];
        sub_in   = use_rot ? {prev[23:0], prev[31:24]} : prev[31:0];
        rcon_idx = (KEY_W == 256) ? {1'b0, rnd[3:1]} : rnd;
        temp     = sub_out ^ (use_rot ? {rcon(rcon_idx), 24'h000000} : 32'h0);
        next_rk[127:96] = base[127:96] ^ temp;
        next_rk[95:64]  = base[95:64]  ^ next_rk[127:96];
        next_rk[63:32]  = base[63:32]  ^ next_rk[95:64];
        next_rk[31:0]   = base[31:0]   ^ next_rk[63:32];
    end

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.a(sub_in[8*g +: 8]), .y(sub_out[8*g +: 8]));
    end

    // Round-key storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (wipe) begin
            for (int i = 0; i <= NR; i++) rk_buf[i] <= '0;
        end else if (accept) begin
            rk_buf[0] <= i_key[KEY_W-1 -: 128];
            if (KEY_W == 256) rk_buf[1] <= i_key[127:0];
        end else if (state == EXPAND) begin
            rk_buf[rnd] <= next_rk;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            rnd       <= 4'd0;
            o_key_rdy <= 1'b1;
            o_done    <= 1'b0;
            o_rk      <= '0;
        end else begin
            o_rk <= (i_rk_rd_idx <= LAST) ? rk_buf[i_rk_rd_idx] : '0;
            if (wipe) begin
                state     <= IDLE;
                rnd       <= 4'd0;
                o_key_rdy <= 1'b1;
                o_done    <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (i_key_vld) begin
                            state     <= EXPAND;
                            rnd       <= FIRST;
                            o_key_rdy <= 1'b0;
                            o_done    <= 1'b0;
                        end
                    end
                    EXPAND: begin
                        if (rnd == LAST) begin
                            state     <= DONE;
                            o_key_rdy <= 1'b1;
                            o_done    <= 1'b1;
                        end else begin
                            rnd <= rnd + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: one AES-128 and one AES-256 instance against a FIPS-197 word-level model.
// Zeroize expectations follow AES_KEY_ZEROIZE_EN.
module tb_aes_key_expand;
    localparam logic [127:0] A1_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_RK10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [255:0] A3_KEY   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] A3_RK14  = 128'hfe4890d1e6188d0b046df344706c631e;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         v128, v256, z128, z256;
    logic [127:0] k128;
    logic [255:0] k256;
    logic [3:0]   x128, x256;
    logic         rdy128, rdy256, done128, done256;
    logic [127:0] rk128, rk256;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_t [0:255];
    logic [127:0] exp_rk [0:14];

    aes_key_expand #(.KEY_W(128)) dut128 (
        .i_clk(clk), .i_rst_n(rst_n), .i_key_vld(v128), .i_key(k128),
        .o_key_rdy(rdy128), .o_done(done128), .i_rk_rd_idx(x128), .o_rk(rk128),
        .i_zeroize(z128)
    );

    aes_key_expand #(.KEY_W(256)) dut256 (
        .i_clk(clk), .i_rst_n(rst_n), .i_key_vld(v256), .i_key(k256),
        .o_key_rdy(rdy256), .o_done(done256), .i_rk_rd_idx(x256), .o_rk(rk256),
        .i_zeroize(z256)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // S-box from the generator-3 walk over GF(2^8) with the affine map.
    task automatic init_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon_of(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 1; i < n; i++) r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
        return r;
    endfunction

    // FIPS-197 word schedule; a 128-bit key sits in the low half of key.
    task automatic build_model(input logic [255:0] key, input int nk);
        logic [31:0] w [0:59];
        logic [31:0] t;
        int nr;
        nr = (nk == 8) ? 14 : 10;
        for (int i = 0; i < nk; i++) w[i] = key[32*(nk-1-i) +: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_of(i/nk), 24'h0};
            else if (nk > 4 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic give_key(input bit wide, input logic [255:0] key);
        check(wide ? "rdy256_before_accept" : "rdy128_before_accept",
              {127'b0, wide ? rdy256 : rdy128}, 128'd1);
        if (wide) begin v256 = 1'b1; k256 = key; end
        else begin v128 = 1'b1; k128 = key[127:0]; end
        step();
        v128 = 1'b0;
        v256 = 1'b0;
    endtask

    task automatic expect_latency(input bit wide, input int already, input int want, input string tag);
        int cycles;
        cycles = already;
        while (!(wide ? done256 : done128) && cycles < 40) begin
            step();
            cycles++;
        end
        check(tag, 128'(cycles), 128'(want));
    endtask

    task automatic read_check(input bit wide, input int idx, input logic [127:0] want, input string tag);
        if (wide) x256 = 4'(idx); else x128 = 4'(idx);
        step();
        check(tag, wide ? rk256 : rk128, want);
    endtask

    task automatic read_all(input bit wide, input string tag);
        for (int r = 0; r <= (wide ? 14 : 10); r++)
            read_check(wide, r, exp_rk[r], $sformatf("%s_rk%0d", tag, r));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] rkey;
        init_sbox();
        rst_n = 1'b0;
        v128 = 1'b0; v256 = 1'b0; z128 = 1'b0; z256 = 1'b0;
        k128 = '0; k256 = '0; x128 = '0; x256 = '0;
        repeat (2) step();
        check("reset_rdy128", {127'b0, rdy128}, 128'd1);
        check("reset_done128", {127'b0, done128}, 128'd0);
        check("reset_rk128", rk128, 128'd0);
        check("reset_rdy256", {127'b0, rdy256}, 128'd1);
        check("reset_done256", {127'b0, done256}, 128'd0);
        check("reset_rk256", rk256, 128'd0);
        rst_n = 1'b1;
        step();

        // FIPS-197 A.1
        build_model({128'b0, A1_KEY}, 4);
        give_key(0, {128'b0, A1_KEY});
        expect_latency(0, 0, 10, "a1_latency");
        read_all(0, "a1");
        read_check(0, 1, A1_RK1, "a1_fips_rk1");
        read_check(0, 10, A1_RK10, "a1_fips_rk10");

        // FIPS-197 A.3
        build_model(A3_KEY, 8);
        give_key(1, A3_KEY);
        expect_latency(1, 0, 13, "a3_latency");
        read_all(1, "a3");
        read_check(1, 14, A3_RK14, "a3_fips_rk14");

        // A different key offered mid-expansion must be dropped
        build_model({128'b0, A1_KEY}, 4);
        give_key(0, {128'b0, A1_KEY});
        repeat (3) step();
        v128 = 1'b1;
        k128 = {$urandom(), $urandom(), $urandom(), $urandom()};
        step();
        check("busy_rdy_c4", {127'b0, rdy128}, 128'd0);
        step();
        check("busy_rdy_c5", {127'b0, rdy128}, 128'd0);
        v128 = 1'b0;
        expect_latency(0, 5, 10, "busy_latency");
        read_all(0, "busy");

        // Asynchronous reset in the middle of expansion
        x128 = 4'd0;
        give_key(0, {128'b0, A1_KEY});
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check("midrst_done", {127'b0, done128}, 128'd0);
        check("midrst_rdy", {127'b0, rdy128}, 128'd1);
        check("midrst_rk", rk128, 128'd0);
        step();
        rst_n = 1'b1;
        step();
        give_key(0, {128'b0, A1_KEY});
        expect_latency(0, 0, 10, "postrst_latency");
        read_all(0, "postrst");

        // Back-to-back restart from DONE with an all-zero key, plus a same-edge read of rk[1]
        give_key(0, {128'b0, A1_KEY});
        expect_latency(0, 0, 10, "b2b_first_latency");
        give_key(0, 256'd0);
        check("restart_done_low", {127'b0, done128}, 128'd0);
        x128 = 4'd1;
        step();
        check("collision_old_rk1", rk128, A1_RK1);
        expect_latency(0, 1, 10, "zero_latency");
        build_model(256'd0, 4);
        read_all(0, "zero");
        read_check(0, 10, Z_RK10, "zero_fips_rk10");
        read_check(0, 15, 128'd0, "oob128_idx15");
        read_check(0, 11, 128'd0, "oob128_idx11");
        read_check(1, 15, 128'd0, "oob256_idx15");

        // Random keys through both widths
        for (int n = 0; n < 3; n++) begin
            rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
            build_model(rkey, 8);
            give_key(1, rkey);
            expect_latency(1, 0, 13, $sformatf("rnd256_%0d_latency", n));
            read_all(1, $sformatf("rnd256_%0d", n));
        end
        for (int n = 0; n < 3; n++) begin
            rkey = {128'b0, $urandom(), $urandom(), $urandom(), $urandom()};
            build_model(rkey, 4);
            give_key(0, rkey);
            expect_latency(0, 0, 10, $sformatf("rnd128_%0d_latency", n));
            read_all(0, $sformatf("rnd128_%0d", n));
        end

        // Key wipe while in DONE
        z128 = 1'b1;
        step();
        z128 = 1'b0;
`ifdef AES_KEY_ZEROIZE_EN
        check("zeroize_done", {127'b0, done128}, 128'd0);
        check("zeroize_rdy", {127'b0, rdy128}, 128'd1);
        for (int r = 0; r <= 10; r++) exp_rk[r] = '0;
        read_all(0, "zeroize");
`else
        check("zeroize_ignored_done", {127'b0, done128}, 128'd1);
        read_all(0, "zeroize_ignored");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
